// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, requester indices and a saturating counter helper
package regfile_pkg;
    localparam int NUM_REGS   = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int DATA_WIDTH = 32;
    localparam int CNT_WIDTH  = 16;
    typedef enum logic {REQ_ALU = 1'b0, REQ_MEM = 1'b1} req_idx_e;
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c, input logic en);
        return (en && c != '1) ? c + 1'b1 : c;
    endfunction
endpackage

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: two-way round-robin grant with a 1-bit preference pointer
module rr_arbiter_2 import regfile_pkg::*; (
    input  logic       clk,
    input  logic       rst,
    input  logic       stall,
    input  logic       accept,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    logic ptr_q, ptr_d;
    always_comb begin
        gnt   = (stall || rst) ? 2'b00 : (&req) ? (ptr_q ? 2'b10 : 2'b01) : req;
        ptr_d = accept ? gnt[REQ_ALU] : ptr_q;
    end
    always_ff @(posedge clk) begin
        if (rst) ptr_q <= 1'b0;
        else     ptr_q <= ptr_d;
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: arbitrates ALU/load writebacks onto one registered write port
module regfile_wb_arbiter import regfile_pkg::*; (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [ADDR_WIDTH-1:0] alu_addr,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  we3,
    output logic [ADDR_WIDTH-1:0] wa3,
    output logic [DATA_WIDTH-1:0] wd3,
    output logic [CNT_WIDTH-1:0]  alu_grants,
    output logic [CNT_WIDTH-1:0]  mem_grants
);
    logic [1:0]            gnt;
    logic                  xfer, wr;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  we3_q, we3_d;
    logic [ADDR_WIDTH-1:0] wa3_q, wa3_d;
    logic [DATA_WIDTH-1:0] wd3_q, wd3_d;
    logic [CNT_WIDTH-1:0]  alu_cnt_q, alu_cnt_d, mem_cnt_q, mem_cnt_d;
    rr_arbiter_2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .stall (stall),
        .accept(xfer),
        .req   ({mem_valid, alu_valid}),
        .gnt   (gnt)
    );
    always_comb begin
        xfer      = |gnt;
        sel_addr  = gnt[REQ_MEM] ? mem_addr : alu_addr;
        sel_data  = gnt[REQ_MEM] ? mem_data : alu_data;
        wr        = xfer && sel_addr != '0;
        we3_d     = wr;
        wa3_d     = wr ? sel_addr : wa3_q;
        wd3_d     = wr ? sel_data : wd3_q;
        alu_cnt_d = sat_inc(alu_cnt_q, gnt[REQ_ALU]);
        mem_cnt_d = sat_inc(mem_cnt_q, gnt[REQ_MEM]);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            we3_q     <= 1'b0;
            wa3_q     <= '0;
            wd3_q     <= '0;
            alu_cnt_q <= '0;
            mem_cnt_q <= '0;
        end else begin
            we3_q     <= we3_d;
            wa3_q     <= wa3_d;
            wd3_q     <= wd3_d;
            alu_cnt_q <= alu_cnt_d;
            mem_cnt_q <= mem_cnt_d;
        end
    end
    assign alu_ready  = gnt[REQ_ALU];
    assign mem_ready  = gnt[REQ_MEM];
    assign we3        = we3_q && !rst;
    assign wa3        = wa3_q;
    assign wd3        = wd3_q;
    assign alu_grants = alu_cnt_q;
    assign mem_grants = mem_cnt_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed self-checking bench for the writeback arbiter
module tb_regfile_wb_arbiter;
    logic        clk, rst, stall;
    logic        alu_valid, alu_ready, mem_valid, mem_ready;
    logic [4:0]  alu_addr, mem_addr, wa3;
    logic [31:0] alu_data, mem_data, wd3;
    logic        we3;
    logic [15:0] alu_grants, mem_grants;
    int n_checks = 0;
    int n_fail = 0;
    regfile_wb_arbiter dut (
        .clk(clk), .rst(rst), .stall(stall),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
        .we3(we3), .wa3(wa3), .wd3(wd3), .alu_grants(alu_grants), .mem_grants(mem_grants)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask
    task automatic test_reset;
        rst = 1'b1; stall = 1'b0;
        alu_valid = 1'b1; mem_valid = 1'b1;
        alu_addr = 5'd4; mem_addr = 5'd6; alu_data = 32'h1; mem_data = 32'h2;
        #1;
        n_checks++;
        if ({alu_ready, mem_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b exp 00", {alu_ready, mem_ready}); end
        tick();
        n_checks++;
        if ({we3, wa3, wd3, alu_grants, mem_grants} !== '0) begin n_fail++; $display("FAIL reset_state: we3=%b wa3=%0d wd3=%h ag=%0d mg=%0d exp all 0", we3, wa3, wd3, alu_grants, mem_grants); end
        alu_valid = 1'b0; mem_valid = 1'b0;
        rst = 1'b0;
        tick();
    endtask
    task automatic test_single_alu;
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
        #1;
        n_checks++;
        if ({alu_ready, mem_ready} !== 2'b10) begin n_fail++; $display("FAIL single_ready: got %b exp 10", {alu_ready, mem_ready}); end
        tick();
        alu_valid = 1'b0;
        n_checks++;
        if ({we3, wa3, wd3} !== {1'b1, 5'd5, 32'hDEADBEEF} || alu_grants !== 16'd1) begin n_fail++; $display("FAIL single_write: we3=%b wa3=%0d wd3=%h ag=%0d exp 1 5 deadbeef 1", we3, wa3, wd3, alu_grants); end
        tick();
        n_checks++;
        if ({we3, wa3, wd3} !== {1'b0, 5'd5, 32'hDEADBEEF}) begin n_fail++; $display("FAIL single_idle: we3=%b wa3=%0d wd3=%h exp 0 5 deadbeef", we3, wa3, wd3); end
    endtask
    task automatic test_contention;
        int an = 0;
        int mn = 0;
        logic exp_alu;
        do_reset();
        alu_valid = 1'b1; mem_valid = 1'b1; alu_addr = 5'd1; mem_addr = 5'd2;
        for (int i = 0; i < 4; i++) begin
            alu_data = 32'hA000_0000 + an;
            mem_data = 32'hB000_0000 + mn;
            exp_alu = (i % 2 == 0);
            #1;
            n_checks++;
            if ({alu_ready, mem_ready} !== {exp_alu, !exp_alu}) begin n_fail++; $display("FAIL contention_grant%0d: got %b exp %b", i, {alu_ready, mem_ready}, {exp_alu, !exp_alu}); end
            tick();
            n_checks++;
            if (exp_alu) begin
                if ({we3, wa3, wd3} !== {1'b1, 5'd1, 32'hA000_0000 + an}) begin n_fail++; $display("FAIL contention_write%0d: we3=%b wa3=%0d wd3=%h", i, we3, wa3, wd3); end
                an++;
            end else begin
                if ({we3, wa3, wd3} !== {1'b1, 5'd2, 32'hB000_0000 + mn}) begin n_fail++; $display("FAIL contention_write%0d: we3=%b wa3=%0d wd3=%h", i, we3, wa3, wd3); end
                mn++;
            end
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        tick();
        n_checks++;
        if (we3 !== 1'b0 || alu_grants !== 16'd2 || mem_grants !== 16'd2) begin n_fail++; $display("FAIL contention_end: we3=%b ag=%0d mg=%0d exp 0 2 2", we3, alu_grants, mem_grants); end
    endtask
    task automatic test_x0;
        mem_valid = 1'b1; mem_addr = 5'd0; mem_data = 32'h1234;
        #1;
        n_checks++;
        if ({alu_ready, mem_ready} !== 2'b01) begin n_fail++; $display("FAIL x0_ready: got %b exp 01", {alu_ready, mem_ready}); end
        tick();
        mem_valid = 1'b0;
        n_checks++;
        if ({we3, wa3, wd3} !== {1'b0, 5'd2, 32'hB000_0001} || mem_grants !== 16'd3) begin n_fail++; $display("FAIL x0_write: we3=%b wa3=%0d wd3=%h mg=%0d exp 0 2 b0000001 3", we3, wa3, wd3, mem_grants); end
    endtask
    task automatic test_stall;
        alu_valid = 1'b1; mem_valid = 1'b1; stall = 1'b1;
        alu_addr = 5'd7; alu_data = 32'h7777_0000; mem_addr = 5'd8; mem_data = 32'h8888_0000;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if ({alu_ready, mem_ready} !== 2'b00) begin n_fail++; $display("FAIL stall_ready%0d: got %b exp 00", i, {alu_ready, mem_ready}); end
            tick();
            n_checks++;
            if (we3 !== 1'b0 || alu_grants !== 16'd2 || mem_grants !== 16'd3) begin n_fail++; $display("FAIL stall_hold%0d: we3=%b ag=%0d mg=%0d exp 0 2 3", i, we3, alu_grants, mem_grants); end
        end
        stall = 1'b0;
        #1;
        n_checks++;
        if ({alu_ready, mem_ready} !== 2'b10) begin n_fail++; $display("FAIL stall_release: got %b exp 10", {alu_ready, mem_ready}); end
        tick();
        alu_valid = 1'b0; mem_valid = 1'b0;
        n_checks++;
        if ({we3, wa3, wd3} !== {1'b1, 5'd7, 32'h7777_0000} || alu_grants !== 16'd3) begin n_fail++; $display("FAIL stall_write: we3=%b wa3=%0d wd3=%h ag=%0d", we3, wa3, wd3, alu_grants); end
    endtask
    task automatic test_reset_mid;
        alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'h99;
        tick();
        alu_valid = 1'b0; rst = 1'b1;
        #1;
        n_checks++;
        if (we3 !== 1'b0) begin n_fail++; $display("FAIL resetmid_we3: got %b exp 0", we3); end
        tick();
        rst = 1'b0;
        n_checks++;
        if (alu_grants !== 16'd0 || mem_grants !== 16'd0 || we3 !== 1'b0) begin n_fail++; $display("FAIL resetmid_cnt: ag=%0d mg=%0d we3=%b exp 0 0 0", alu_grants, mem_grants, we3); end
        alu_valid = 1'b1; mem_valid = 1'b1;
        #1;
        n_checks++;
        if ({alu_ready, mem_ready} !== 2'b10) begin n_fail++; $display("FAIL resetmid_ptr: got %b exp 10", {alu_ready, mem_ready}); end
        alu_valid = 1'b0; mem_valid = 1'b0;
    endtask
    task automatic test_saturation;
        do_reset();
        alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h3;
        repeat (16'hFFFE) tick();
        n_checks++;
        if (alu_grants !== 16'hFFFE) begin n_fail++; $display("FAIL sat_preload: got %h exp fffe", alu_grants); end
        tick();
        n_checks++;
        if (alu_grants !== 16'hFFFF) begin n_fail++; $display("FAIL sat_max: got %h exp ffff", alu_grants); end
        tick();
        tick();
        n_checks++;
        if (alu_grants !== 16'hFFFF || mem_grants !== 16'd0) begin n_fail++; $display("FAIL sat_hold: ag=%h mg=%h exp ffff 0000", alu_grants, mem_grants); end
        alu_valid = 1'b0;
    endtask
    initial begin
        test_reset();
        test_single_alu();
        test_contention();
        test_x0();
        test_stall();
        test_reset_mid();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL use parameters from package regfile_pkg: NUM_REGS=32 (register count), ADDR_WIDTH=5 (register address width), DATA_WIDTH=32 (write data width), CNT_WIDTH=16 (grant counter width).
REQ-002 SHALL have one clock and a synchronous, active-high reset, with these ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- stall  in  1  pipeline stall; blocks all grants
- alu_valid  in  1  ALU writeback request
- alu_ready  out  1  ALU request accepted this cycle
- alu_addr  in  ADDR_WIDTH  ALU destination register
- alu_data  in  DATA_WIDTH  ALU result
- mem_valid  in  1  load-unit writeback request
- mem_ready  out  1  load request accepted this cycle
- mem_addr  in  ADDR_WIDTH  load destination register
- mem_data  in  DATA_WIDTH  load result
- we3  out  1  register-file write enable
- wa3  out  ADDR_WIDTH  register-file write address
- wd3  out  DATA_WIDTH  register-file write data
- alu_grants  out  CNT_WIDTH  accepted ALU transfers
- mem_grants  out  CNT_WIDTH  accepted load transfers

Function
REQ-003 SHALL complete a transfer on a requester in any cycle where its valid and ready are both 1.
REQ-004 SHALL drive the ready outputs combinationally from the valids, stall, rst and the priority pointer, and SHALL assert at most one ready per cycle.
REQ-005 SHALL hold alu_ready and mem_ready at 0 whenever stall=1 or rst=1.
REQ-006 SHALL raise the ready of a requester that is the only valid one, when stall=0.
REQ-007 SHALL, when both requesters are valid and stall=0, grant the requester selected by a 1-bit round-robin pointer (0 = ALU preferred, 1 = MEM preferred).
REQ-008 SHALL update the pointer only on a completed transfer, setting it to prefer the requester that was not granted.
REQ-009 SHALL register the write port with a latency of exactly one cycle: a transfer in cycle N drives we3=1, wa3=addr and wd3=data in cycle N+1 only.
REQ-010 SHALL accept a transfer with addr=0 but keep we3=0 in cycle N+1; wa3 and wd3 SHALL then hold their previous values.
REQ-011 SHALL drive we3=0 in any cycle that follows a cycle with no completed transfer, holding wa3 and wd3 stable.
REQ-012 SHALL grant same-address requests from both requesters in consecutive cycles, in round-robin order, without merging or dropping either; ordering between requesters is the producer's responsibility.
REQ-013 SHALL require producers to hold valid, addr and data stable until the transfer completes; the arbiter SHALL NOT capture anything while ready=0.
REQ-014 SHALL increment the matching counter by 1 on every completed transfer, including addr=0 transfers, and SHALL saturate each counter at 2^CNT_WIDTH-1 with no wrap.
REQ-015 SHALL keep the pointer, the write-port registers and the counters unchanged while stall=1.

Reset
REQ-016 SHALL, while rst=1 at a rising clk edge, set we3=0, wa3=0, wd3=0, pointer=0 (ALU preferred), alu_grants=0 and mem_grants=0.
REQ-017 SHALL discard any request present in a reset cycle; a reset asserted the cycle after a transfer SHALL force we3=0, and that write is lost.
REQ-018 SHALL resume arbitration in the first cycle with rst=0.

Structure
REQ-019 SHALL place NUM_REGS, ADDR_WIDTH, DATA_WIDTH, CNT_WIDTH and the requester index enum (REQ_ALU=0, REQ_MEM=1) in package regfile_pkg.
REQ-020 SHALL implement the grant logic and pointer in one sub-module, rr_arbiter_2 (inputs: req[1:0], stall, rst, clk, accept; output: gnt[1:0]).
REQ-021 SHALL implement write-port registers and counters in regfile_wb_arbiter itself, with no other sub-modules.

Verification
REQ-022 Single ALU: alu_valid=1, addr=5, data=0xDEADBEEF -> alu_ready=1 in the same cycle; next cycle we3=1, wa3=5, wd3=0xDEADBEEF; alu_grants=1.
REQ-023 Contention after reset: both valid for 4 cycles (ALU addr=1, MEM addr=2, new data per transfer) -> grant order ALU, MEM, ALU, MEM; we3 high for 4 consecutive cycles starting 1 cycle later.
REQ-024 x0 write: mem_valid=1, addr=0, data=0x1234 -> mem_ready=1 and mem_grants increments; next cycle we3=0 and wa3/wd3 unchanged.
REQ-025 Stall: both valid and stall=1 for 3 cycles -> both readys 0, we3=0, counters and pointer unchanged; stall drops -> ALU granted first if the pointer was 0.
REQ-026 Reset mid-stream: transfer in cycle N, rst=1 in cycle N+1 -> we3=0 in N+1, counters 0, pointer 0 afterwards.
REQ-027 Saturation: preload alu_grants to 0xFFFE by 0xFFFE transfers, then 3 more -> counter reads 0xFFFF and stays there.
